// File: rtl/punc_control.sv
// punc_control -- multi-cycle control unit for the PUNC datapath.
//
// States:
//   state  | meaning
//   FETCH  | drive PC onto memory address, load IR
//   DECODE | increment PC
//   EXEC   | execute the opcode in IR (first memory access for LDI/STI)
//   EXEC2  | second memory access of LDI/STI via the store register
//   HALT   | TRAP seen; everything idle until rst
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   ir, n, z, p               instruction register and condition flags
//   pc_* / ir_ld              PC clear/increment/load and selects, IR load
//   addr_mem_sel, w_en_mem    memory address mux, memory write
//   w_en_rf, w_rf_sel         RF write enable and write-data mux
//   r_addr_0_rf, r_addr_1_rf,
//   w_addr_rf                 RF port addresses
//   store_ld                  store-register load (indirect address)
//   sext_data, a_sel, b_sel,
//   alu_sel                   ALU operand selects, immediate and op
//   nzp_sel, n_ld, z_ld, p_ld flag source and flag loads
//   halted                    high while in HALT
//
// Only the state is registered; every output decodes from state, ir and
// the flags, so an output changes in the same cycle the state does.
module punc_control (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] ir,
  input  logic        n,
  input  logic        z,
  input  logic        p,
  output logic        pc_ld,
  output logic        pc_clr,
  output logic        pc_inc,
  output logic        ir_ld,
  output logic        pc_data_sel,
  output logic        pc_add_sel,
  output logic [1:0]  addr_mem_sel,
  output logic        w_en_mem,
  output logic        w_en_rf,
  output logic        store_ld,
  output logic [1:0]  w_rf_sel,
  output logic [2:0]  r_addr_0_rf,
  output logic [2:0]  r_addr_1_rf,
  output logic [2:0]  w_addr_rf,
  output logic [15:0] sext_data,
  output logic        a_sel,
  output logic        b_sel,
  output logic [1:0]  alu_sel,
  output logic        nzp_sel,
  output logic        n_ld,
  output logic        z_ld,
  output logic        p_ld,
  output logic        halted
);

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_EXEC2, S_HALT} state_t;

  localparam logic [3:0] OP_BR  = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_LD  = 4'b0010;
  localparam logic [3:0] OP_ST  = 4'b0011;
  localparam logic [3:0] OP_JSR = 4'b0100;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_LDR = 4'b0110;
  localparam logic [3:0] OP_STR = 4'b0111;
  localparam logic [3:0] OP_NOT = 4'b1001;
  localparam logic [3:0] OP_LDI = 4'b1010;
  localparam logic [3:0] OP_STI = 4'b1011;
  localparam logic [3:0] OP_JMP = 4'b1100;
  localparam logic [3:0] OP_LEA = 4'b1110;
  localparam logic [3:0] OP_TRP = 4'b1111;

  state_t      state;
  logic [3:0]  opcode;
  logic [15:0] sext5, sext6, sext9;
  logic        br_taken;
  logic        pc_rel, base_rel, flag_ld;

  assign opcode   = ir[15:12];
  assign sext5    = {{11{ir[4]}}, ir[4:0]};
  assign sext6    = {{10{ir[5]}}, ir[5:0]};
  assign sext9    = {{7{ir[8]}},  ir[8:0]};
  assign br_taken = (ir[11] & n) | (ir[10] & z) | (ir[9] & p);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_FETCH;
    end else begin
      case (state)
        S_FETCH:  state <= S_DECODE;
        S_DECODE: state <= S_EXEC;
        S_EXEC: begin
          if (opcode == OP_LDI || opcode == OP_STI) state <= S_EXEC2;
          else if (opcode == OP_TRP)                state <= S_HALT;
          else                                      state <= S_FETCH;
        end
        S_EXEC2:  state <= S_FETCH;
        S_HALT:   state <= S_HALT;
        default:  state <= S_FETCH;
      endcase
    end
  end

  always_comb begin
    pc_ld = 1'b0; pc_clr = 1'b0; pc_inc = 1'b0; ir_ld = 1'b0;
    pc_data_sel = 1'b0; pc_add_sel = 1'b0; addr_mem_sel = 2'b00;
    w_en_mem = 1'b0; w_en_rf = 1'b0; store_ld = 1'b0; w_rf_sel = 2'b00;
    r_addr_0_rf = 3'd0; r_addr_1_rf = 3'd0; w_addr_rf = 3'd0;
    sext_data = 16'h0000; a_sel = 1'b0; b_sel = 1'b0; alu_sel = 2'b00;
    nzp_sel = 1'b0; halted = 1'b0;
    pc_rel = 1'b0; base_rel = 1'b0; flag_ld = 1'b0;

    if (rst) begin
      pc_clr = 1'b1;
    end else begin
      case (state)
        S_FETCH: ir_ld = 1'b1;
        S_DECODE: pc_inc = 1'b1;
        S_EXEC: begin
          case (opcode)
            OP_ADD, OP_AND: begin
              alu_sel     = (opcode == OP_AND) ? 2'b01 : 2'b00;
              a_sel       = 1'b1;
              r_addr_0_rf = ir[8:6];
              if (ir[5]) begin
                b_sel     = 1'b1;
                sext_data = sext5;
              end else begin
                r_addr_1_rf = ir[2:0];
              end
              w_addr_rf = ir[11:9];
              w_rf_sel  = 2'b10;
              w_en_rf   = 1'b1;
              flag_ld   = 1'b1;
            end
            OP_NOT: begin
              alu_sel     = 2'b11;
              a_sel       = 1'b1;
              r_addr_0_rf = ir[8:6];
              w_addr_rf   = ir[11:9];
              w_rf_sel    = 2'b10;
              w_en_rf     = 1'b1;
              flag_ld     = 1'b1;
            end
            OP_LD, OP_LDR: begin
              pc_rel       = (opcode == OP_LD);
              base_rel     = (opcode == OP_LDR);
              addr_mem_sel = 2'b01;
              w_rf_sel     = 2'b01;
              w_addr_rf    = ir[11:9];
              w_en_rf      = 1'b1;
              flag_ld      = 1'b1;
              nzp_sel      = 1'b1;
            end
            OP_ST, OP_STR: begin
              pc_rel       = (opcode == OP_ST);
              base_rel     = (opcode == OP_STR);
              addr_mem_sel = 2'b01;
              r_addr_1_rf  = ir[11:9];
              w_en_mem     = 1'b1;
            end
            OP_LDI, OP_STI: begin
              // Pointer fetched here lands in the store register for EXEC2.
              pc_rel       = 1'b1;
              addr_mem_sel = 2'b01;
              store_ld     = 1'b1;
            end
            OP_LEA: begin
              pc_rel    = 1'b1;
              w_addr_rf = ir[11:9];
              w_rf_sel  = 2'b10;
              w_en_rf   = 1'b1;
            end
            OP_BR: begin
              if (br_taken) begin
                pc_ld      = 1'b1;
                pc_add_sel = 1'b1;
              end
            end
            OP_JSR: begin
              // R7 takes the pre-jump PC on the same edge the PC reloads.
              w_addr_rf = 3'd7;
              w_rf_sel  = 2'b00;
              w_en_rf   = 1'b1;
              pc_ld     = 1'b1;
              if (!ir[11]) begin
                pc_data_sel = 1'b1;
                alu_sel     = 2'b10;
                a_sel       = 1'b1;
                r_addr_0_rf = ir[8:6];
              end
            end
            OP_JMP: begin
              pc_ld       = 1'b1;
              pc_data_sel = 1'b1;
              alu_sel     = 2'b10;
              a_sel       = 1'b1;
              r_addr_0_rf = ir[8:6];
            end
            default: ;
          endcase
        end
        S_EXEC2: begin
          addr_mem_sel = 2'b10;
          if (opcode == OP_LDI) begin
            w_rf_sel  = 2'b01;
            w_addr_rf = ir[11:9];
            w_en_rf   = 1'b1;
            flag_ld   = 1'b1;
            nzp_sel   = 1'b1;
          end else begin
            r_addr_1_rf = ir[11:9];
            w_en_mem    = 1'b1;
          end
        end
        S_HALT: halted = 1'b1;
        default: ;
      endcase

      if (pc_rel) begin
        a_sel     = 1'b0;
        b_sel     = 1'b1;
        sext_data = sext9;
      end
      if (base_rel) begin
        a_sel       = 1'b1;
        r_addr_0_rf = ir[8:6];
        b_sel       = 1'b1;
        sext_data   = sext6;
      end
    end
  end

  assign n_ld = flag_ld;
  assign z_ld = flag_ld;
  assign p_ld = flag_ld;

endmodule

// File: tb/tb_punc_control.sv
module tb_punc_control;

   typedef struct packed {
      logic        pc_ld;
      logic        pc_clr;
      logic        pc_inc;
      logic        ir_ld;
      logic        pc_data_sel;
      logic        pc_add_sel;
      logic [1:0]  addr_mem_sel;
      logic        w_en_mem;
      logic        w_en_rf;
      logic        store_ld;
      logic [1:0]  w_rf_sel;
      logic [2:0]  r0;
      logic [2:0]  r1;
      logic [2:0]  wa;
      logic [15:0] sext_data;
      logic        a_sel;
      logic        b_sel;
      logic [1:0]  alu_sel;
      logic        nzp_sel;
      logic        n_ld;
      logic        z_ld;
      logic        p_ld;
      logic        halted;
   } outs_t;

   logic        clk, rst, n, z, p;
   logic [15:0] ir;
   logic        pc_ld, pc_clr, pc_inc, ir_ld, pc_data_sel, pc_add_sel;
   logic [1:0]  addr_mem_sel, w_rf_sel, alu_sel;
   logic        w_en_mem, w_en_rf, store_ld, a_sel, b_sel, nzp_sel;
   logic        n_ld, z_ld, p_ld, halted;
   logic [2:0]  r_addr_0_rf, r_addr_1_rf, w_addr_rf;
   logic [15:0] sext_data;

   outs_t obs, e;
   int n_checks = 0;
   int n_fail   = 0;

   punc_control dut (
      .clk(clk), .rst(rst), .ir(ir), .n(n), .z(z), .p(p),
      .pc_ld(pc_ld), .pc_clr(pc_clr), .pc_inc(pc_inc), .ir_ld(ir_ld),
      .pc_data_sel(pc_data_sel), .pc_add_sel(pc_add_sel),
      .addr_mem_sel(addr_mem_sel), .w_en_mem(w_en_mem), .w_en_rf(w_en_rf),
      .store_ld(store_ld), .w_rf_sel(w_rf_sel), .r_addr_0_rf(r_addr_0_rf),
      .r_addr_1_rf(r_addr_1_rf), .w_addr_rf(w_addr_rf), .sext_data(sext_data),
      .a_sel(a_sel), .b_sel(b_sel), .alu_sel(alu_sel), .nzp_sel(nzp_sel),
      .n_ld(n_ld), .z_ld(z_ld), .p_ld(p_ld), .halted(halted)
   );

   assign obs = {pc_ld, pc_clr, pc_inc, ir_ld, pc_data_sel, pc_add_sel,
                 addr_mem_sel, w_en_mem, w_en_rf, store_ld, w_rf_sel,
                 r_addr_0_rf, r_addr_1_rf, w_addr_rf, sext_data,
                 a_sel, b_sel, alu_sel, nzp_sel, n_ld, z_ld, p_ld, halted};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag);
      n_checks++;
      if (obs !== e) begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, e);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic next_instr(input logic [15:0] v);
      ir = v;
      tick();
      tick();
   endtask

   initial begin
      rst = 1'b1; ir = 16'h1261; n = 1'b0; z = 1'b0; p = 1'b0;
      #2;
      e = '0; e.pc_clr = 1'b1;
      chk("rst_hold");
      tick();
      rst = 1'b0; #1;
      e = '0; e.ir_ld = 1'b1;
      chk("fetch");
      tick();
      e = '0; e.pc_inc = 1'b1;
      chk("decode");
      tick();
      e = '0; e.r0 = 3'd1; e.a_sel = 1'b1; e.b_sel = 1'b1; e.sext_data = 16'h0001;
      e.wa = 3'd1; e.w_rf_sel = 2'b10; e.w_en_rf = 1'b1;
      e.n_ld = 1'b1; e.z_ld = 1'b1; e.p_ld = 1'b1;
      chk("add_imm");
      tick();
      e = '0; e.ir_ld = 1'b1;
      chk("fetch_after_add");

      next_instr(16'h1042);
      e = '0; e.r0 = 3'd1; e.r1 = 3'd2; e.a_sel = 1'b1; e.wa = 3'd0;
      e.w_rf_sel = 2'b10; e.w_en_rf = 1'b1; e.n_ld = 1'b1; e.z_ld = 1'b1; e.p_ld = 1'b1;
      chk("add_reg");
      tick();

      next_instr(16'h5A7F);
      e = '0; e.alu_sel = 2'b01; e.r0 = 3'd1; e.a_sel = 1'b1; e.b_sel = 1'b1;
      e.sext_data = 16'hFFFF; e.wa = 3'd5; e.w_rf_sel = 2'b10; e.w_en_rf = 1'b1;
      e.n_ld = 1'b1; e.z_ld = 1'b1; e.p_ld = 1'b1;
      chk("and_imm");
      tick();

      z = 1'b1;
      next_instr(16'h0402);
      e = '0; e.pc_ld = 1'b1; e.pc_add_sel = 1'b1;
      chk("br_taken");
      tick();

      z = 1'b0; n = 1'b1;
      next_instr(16'h0402);
      e = '0;
      chk("br_not_taken");
      tick();

      n = 1'b1; z = 1'b1; p = 1'b1;
      next_instr(16'h0002);
      e = '0;
      chk("br_nzp_000");
      tick();
      n = 1'b0; z = 1'b0; p = 1'b0;

      next_instr(16'hA3FF);
      e = '0; e.addr_mem_sel = 2'b01; e.store_ld = 1'b1; e.b_sel = 1'b1;
      e.sext_data = 16'hFFFF;
      chk("ldi_exec");
      tick();
      e = '0; e.addr_mem_sel = 2'b10; e.w_rf_sel = 2'b01; e.wa = 3'd1; e.w_en_rf = 1'b1;
      e.nzp_sel = 1'b1; e.n_ld = 1'b1; e.z_ld = 1'b1; e.p_ld = 1'b1;
      chk("ldi_exec2");
      tick();
      e = '0; e.ir_ld = 1'b1;
      chk("ldi_fetch_5th");

      next_instr(16'hB5FE);
      e = '0; e.addr_mem_sel = 2'b01; e.store_ld = 1'b1; e.b_sel = 1'b1;
      e.sext_data = 16'hFFFE;
      chk("sti_exec");
      tick();
      e = '0; e.addr_mem_sel = 2'b10; e.r1 = 3'd2; e.w_en_mem = 1'b1;
      chk("sti_exec2");
      tick();

      next_instr(16'h4803);
      e = '0; e.wa = 3'd7; e.w_rf_sel = 2'b00; e.w_en_rf = 1'b1; e.pc_ld = 1'b1;
      chk("jsr");
      tick();

      next_instr(16'h4080);
      e = '0; e.wa = 3'd7; e.w_en_rf = 1'b1; e.pc_ld = 1'b1; e.pc_data_sel = 1'b1;
      e.alu_sel = 2'b10; e.a_sel = 1'b1; e.r0 = 3'd2;
      chk("jsrr");
      tick();

      next_instr(16'h6A7F);
      e = '0; e.addr_mem_sel = 2'b01; e.a_sel = 1'b1; e.r0 = 3'd1; e.b_sel = 1'b1;
      e.sext_data = 16'hFFFF; e.w_rf_sel = 2'b01; e.wa = 3'd5; e.w_en_rf = 1'b1;
      e.nzp_sel = 1'b1; e.n_ld = 1'b1; e.z_ld = 1'b1; e.p_ld = 1'b1;
      chk("ldr");
      tick();

      next_instr(16'hA3FF);
      tick();
      rst = 1'b1; #1;
      e = '0; e.pc_clr = 1'b1;
      chk("rst_in_exec2");
      tick();
      rst = 1'b0; #1;
      e = '0; e.ir_ld = 1'b1;
      chk("fetch_after_exec2_rst");

      next_instr(16'hF025);
      e = '0;
      chk("trap_exec");
      for (int i = 0; i < 10; i++) begin
         tick();
         e = '0; e.halted = 1'b1;
         chk("halt_hold");
      end
      rst = 1'b1; #1;
      e = '0; e.pc_clr = 1'b1;
      chk("rst_in_halt");
      tick();
      rst = 1'b0; #1;
      e = '0; e.ir_ld = 1'b1;
      chk("fetch_after_halt");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
